// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_MAIN_G  = 3'd0,
    S_MAIN_Y  = 3'd1,
    S_RED_M2S = 3'd2,
    S_SIDE_G  = 3'd3,
    S_SIDE_Y  = 3'd4,
    S_RED_S2M = 3'd5
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b; else m = m;
    if (c > m) m = c; else m = m;
    if (d > m) m = d; else m = m;
    return m;
  endfunction

  // Returns {main_lamp, side_lamp}; any state other than a road's own green/yellow shows red.
  function automatic logic [5:0] lamp_decode(input state_e s);
    logic [5:0] l;
    case (s)
      S_MAIN_G: l = {LAMP_GRN, LAMP_RED};
      S_MAIN_Y: l = {LAMP_YEL, LAMP_RED};
      S_SIDE_G: l = {LAMP_RED, LAMP_GRN};
      S_SIDE_Y: l = {LAMP_RED, LAMP_YEL};
      default:  l = {LAMP_RED, LAMP_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks, in the cycle the count is TICK_DIV-1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Next prescaler count, wrapping at TICK_DIV-1.
  always_comb begin
    if (cnt_q == CW'(TICK_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler flops; tick is registered from the next count so it aligns with cnt_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CW'(TICK_DIV - 1));
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side road sequencing FSM with dwell timer, pedestrian latch and lamp drive.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned MIN_MAIN_G = 20,
  parameter int unsigned SIDE_G     = 10,
  parameter int unsigned YEL        = 3,
  parameter int unsigned RED_CLR    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state
);

  localparam int unsigned TW = $clog2(max4(MIN_MAIN_G, SIDE_G, YEL, RED_CLR) + 1);

  logic          tick;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pending_q, ped_pending_d;
  logic          walk_en_q, walk_en_d;
  logic [5:0]    lamps_q, lamps_d;
  logic          walk_q, walk_d;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next-state, timer and pedestrian latch logic; lamps decoded from the next state.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    ped_pending_d = ped_pending_q | ped_req;
    walk_en_d     = walk_en_q;
    if (tick) begin
      timer_d = timer_q + TW'(1);
      case (state_q)
        S_MAIN_G: begin
          if (timer_q == TW'(MIN_MAIN_G - 1)) begin
            timer_d = timer_q;
            if (side_car | ped_pending_q) begin
              state_d = S_MAIN_Y;
              timer_d = '0;
            end else begin
              state_d = S_MAIN_G;
            end
          end else begin
            state_d = S_MAIN_G;
          end
        end
        S_MAIN_Y: begin
          if (timer_q == TW'(YEL - 1)) begin
            state_d = S_RED_M2S;
            timer_d = '0;
          end else begin
            state_d = S_MAIN_Y;
          end
        end
        S_RED_M2S: begin
          // A request in the very cycle of the handover still joins this walk.
          if (timer_q == TW'(RED_CLR - 1)) begin
            state_d       = S_SIDE_G;
            timer_d       = '0;
            walk_en_d     = ped_pending_q | ped_req;
            ped_pending_d = 1'b0;
          end else begin
            state_d = S_RED_M2S;
          end
        end
        S_SIDE_G: begin
          if (timer_q == TW'(SIDE_G - 1)) begin
            state_d   = S_SIDE_Y;
            timer_d   = '0;
            walk_en_d = 1'b0;
          end else begin
            state_d = S_SIDE_G;
          end
        end
        S_SIDE_Y: begin
          if (timer_q == TW'(YEL - 1)) begin
            state_d = S_RED_S2M;
            timer_d = '0;
          end else begin
            state_d = S_SIDE_Y;
          end
        end
        S_RED_S2M: begin
          if (timer_q == TW'(RED_CLR - 1)) begin
            state_d = S_MAIN_G;
            timer_d = '0;
          end else begin
            state_d = S_RED_S2M;
          end
        end
        default: begin
          state_d = S_MAIN_G;
          timer_d = '0;
        end
      endcase
    end else begin
      timer_d = timer_q;
    end
    lamps_d = lamp_decode(state_d);
    walk_d  = (state_d == S_SIDE_G) & walk_en_d;
  end

  // All controller state plus output registers that update together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_MAIN_G;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      walk_en_q     <= 1'b0;
      lamps_q       <= {LAMP_GRN, LAMP_RED};
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      walk_en_q     <= walk_en_d;
      lamps_q       <= lamps_d;
      walk_q        <= walk_d;
    end
  end

  assign main_light = lamps_q[5:3];
  assign side_light = lamps_q[2:0];
  assign walk       = walk_q;
  assign state      = state_q;

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequencing controller for a two-road intersection: a main road and a side road with a vehicle sensor and a pedestrian push-button. The main road holds green until it has served a minimum dwell and the side road has demand. The controller then runs a fixed yellow/all-red/side-green/yellow/all-red cycle. It sits above the state-holding flops of the traffic-signal design and drives the lamp outputs directly; all timing derives from an internal tick prescaler.

## Interface
- TICK_DIV, 100_000_000 — clk cycles per tick; ≥2
- MIN_MAIN_G, 20 — minimum main-green dwell in ticks; ≥1
- SIDE_G, 10 — side-green dwell in ticks; ≥1
- YEL, 3 — yellow dwell in ticks, both roads; ≥1
- RED_CLR, 1 — all-red clearance dwell in ticks; ≥1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- side_car  in  1  side-road vehicle present, level, synchronous to clk
- ped_req  in  1  pedestrian request, synchronous to clk, any width (≥1 cycle)
- main_light  out  3  {red, yellow, green}, one-hot
- side_light  out  3  {red, yellow, green}, one-hot
- walk  out  1  pedestrian walk lamp
- state  out  3  current state encoding, for debug

## Operation
- Clocking and reset: one clock, `clk`. Reset is `reset`, asynchronous and active-high.
- States: MAIN_G, MAIN_Y, RED_M2S, SIDE_G, SIDE_Y, RED_S2M.
  - State encodings are 0..5 in that order.
  - Reset state is MAIN_G.
- Lamps (Moore, decoded from the state register only):
  - MAIN_G: main green, side red.
  - MAIN_Y: main yellow, side red.
  - RED_M2S and RED_S2M: both red.
  - SIDE_G: main red, side green.
  - SIDE_Y: main red, side yellow.
- walk is 1 only in SIDE_G when walk_en=1.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where counter==TICK_DIV-1.
- Dwell timer: cleared to 0 on every state change, and advances only on tick.
- Timed states (dwell D is YEL, RED_CLR or SIDE_G):
  - On a tick with timer==D-1, move to the next state.
  - Otherwise the timer increments.
- MAIN_G:
  - Timer saturates at MIN_MAIN_G-1.
  - Exit to MAIN_Y on a tick where timer==MIN_MAIN_G-1 and (side_car | ped_pending).
  - Otherwise it stays indefinitely.
- Sequence: MAIN_Y→RED_M2S→SIDE_G→SIDE_Y→RED_S2M→MAIN_G.
- Pedestrian latch:
  - ped_pending <= ped_pending | ped_req every cycle, except on the RED_M2S→SIDE_G transition edge.
  - On that edge: walk_en <= ped_pending | ped_req, and ped_pending <= 0.
  - walk_en is cleared on the SIDE_G→SIDE_Y edge.
  - A request arriving during SIDE_G latches for the next cycle and is not added to the current walk.
- Reset values: state=MAIN_G, timer=0, prescaler=0, ped_pending=0, walk_en=0. Outputs: main_light=3'b001, side_light=3'b100, walk=0.
- Reset mid-cycle: all registers return to their reset values immediately and asynchronously, with no lamp glitch sequence. Any pending request is discarded.
- side_car dropping during MAIN_Y or later does not abort the cycle.

## Timing
- State, timer, walk_en and ped_pending update only on rising clk edges; the transitions above are additionally gated by tick.
- Outputs are combinational from registered state and walk_en; they change in the same cycle the state register updates (zero added latency).
- Dwell for timed state D = exactly D×TICK_DIV clk cycles.
- MAIN_G dwell ≥ MIN_MAIN_G×TICK_DIV cycles, measured from entry.
- Demand present before the minimum dwell expires causes exit at exactly the minimum.
- Demand arriving after the minimum dwell causes exit on the first tick at which demand is sampled high.
- Never both roads non-red simultaneously, in any cycle.
- Timer width: $clog2(max(MIN_MAIN_G, SIDE_G, YEL, RED_CLR)+1). Prescaler width: $clog2(TICK_DIV).

## Structure
- Package traffic_pkg holds:
  - State enum (3-bit, encodings above).
  - Lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick) holds the prescaler.
- FSM, timer, pedestrian latch and lamp decode live in traffic_light_ctrl.

## Test plan
All scenarios use TICK_DIV=4, MIN_MAIN_G=3, YEL=2, RED_CLR=1, SIDE_G=4.
- Reset with no demand for 200 cycles → state=MAIN_G throughout, main_light=001, side_light=100, walk=0.
- side_car=1 held from reset:
  - MAIN_G is left after 12 cycles.
  - Then MAIN_Y for 8 cycles, RED_M2S 4, SIDE_G 16, SIDE_Y 8, RED_S2M 4, then MAIN_G.
  - walk=0 throughout.
- side_car=1 asserted 40 cycles after reset → MAIN_Y entered on the first tick after the cycle in which side_car is first high.
- One-cycle ped_req pulse at cycle 5, side_car=0 → full cycle runs, with walk=1 for exactly the 16 SIDE_G cycles.
- ped_req pulse during SIDE_G:
  - walk stays as is for the current green.
  - ped_pending=1 afterwards.
  - Next MAIN_G exits after its 12-cycle minimum, and that SIDE_G has walk=1.
- reset pulsed mid-SIDE_G:
  - Outputs return to 001/100/walk=0 asynchronously, in the same cycle.
  - Subsequent timing restarts from the prescaler at 0.
  - A conflict checker asserts across all tests that main and side lamps are never both non-red.
